// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared constants and types for the memory port arbiter and the memory it
// fronts.
//   addr_width           byte address width
//   data_width           memory word width
//   mem_simulated_delay  memory ack latency in cycles (request edge to ack)
//   arb_state_e          arbiter FSM states
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int addr_width          = 32;
    localparam int data_width          = 32;
    localparam int mem_simulated_delay = 5;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational round-robin picker. The search starts at last_grant+1
// and wraps modulo num_ports; the first requesting port found wins.
//   req          in   num_ports   request vector
//   last_grant   in   idx_width   most recently granted port
//   grant_valid  out  1           at least one request present
//   grant_idx    out  idx_width   winning port (0 when grant_valid is 0)
// -----------------------------------------------------------------------------
module rr_priority_picker
    import mem_port_arbiter_pkg::*;
#(
    parameter int num_ports = 2,
    parameter int idx_width = $clog2(num_ports)
) (
    input  logic [num_ports-1:0] req,
    input  logic [idx_width-1:0] last_grant,
    output logic                 grant_valid,
    output logic [idx_width-1:0] grant_idx
);

    always_comb begin
        int cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= num_ports; k++) begin
            cand = (int'(last_grant) + k) % num_ports;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_width'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, one-request-at-a-time memory between num_ports
// requesters. Each port has one pending slot; the FSM issues one pending
// request at a time (round-robin), waits for the memory ack and returns the
// ack plus read data to the owning port.
//   clk, rst_n      clock, asynchronous active-low reset
//   port_rd_req     in   per-port read request pulse
//   port_wr_req     in   per-port write request pulse (wins over read)
//   port_addr       in   per-port byte address, port i at slice i
//   port_wr_data    in   per-port write data, port i at slice i
//   port_rd_data    out  per-port read data, valid with that port's ack
//   port_busy       out  port has a request pending or in flight
//   port_ack        out  one-cycle completion pulse per port
//   mem_rd_req/mem_wr_req/mem_addr/mem_wr_data  out  memory request side
//   mem_rd_data/mem_busy/mem_ack                 in   memory response side
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int num_ports = 2,
    parameter int idx_width = $clog2(num_ports)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [num_ports-1:0]            port_rd_req,
    input  logic [num_ports-1:0]            port_wr_req,
    input  logic [num_ports*addr_width-1:0] port_addr,
    input  logic [num_ports*data_width-1:0] port_wr_data,
    output logic [num_ports*data_width-1:0] port_rd_data,
    output logic [num_ports-1:0]            port_busy,
    output logic [num_ports-1:0]            port_ack,
    output logic                            mem_rd_req,
    output logic                            mem_wr_req,
    output logic [addr_width-1:0]           mem_addr,
    output logic [data_width-1:0]           mem_wr_data,
    input  logic [data_width-1:0]           mem_rd_data,
    input  logic                            mem_busy,
    input  logic                            mem_ack
);

    arb_state_e                      state_q, state_d;
    logic [idx_width-1:0]            last_grant_q, last_grant_d;
    logic [idx_width-1:0]            grant_q, grant_d;

    logic [num_ports-1:0]            pend_vld_q, pend_vld_d;
    logic [num_ports-1:0]            pend_wr_q, pend_wr_d;
    logic [addr_width-1:0]           pend_addr_q [num_ports];
    logic [addr_width-1:0]           pend_addr_d [num_ports];
    logic [data_width-1:0]           pend_data_q [num_ports];
    logic [data_width-1:0]           pend_data_d [num_ports];

    logic                            mem_rd_req_q, mem_rd_req_d;
    logic                            mem_wr_req_q, mem_wr_req_d;
    logic [addr_width-1:0]           mem_addr_q, mem_addr_d;
    logic [data_width-1:0]           mem_wr_data_q, mem_wr_data_d;
    logic [num_ports-1:0]            port_ack_q, port_ack_d;
    logic [num_ports*data_width-1:0] port_rd_data_q, port_rd_data_d;

    logic                            pick_vld;
    logic [idx_width-1:0]            pick_idx;

    // Only consulted in IDLE, where nothing is in flight, so every pending
    // slot is an unissued request.
    rr_priority_picker #(
        .num_ports (num_ports),
        .idx_width (idx_width)
    ) u_picker (
        .req         (pend_vld_q),
        .last_grant  (last_grant_q),
        .grant_valid (pick_vld),
        .grant_idx   (pick_idx)
    );

    // Pending slots: capture only into an empty slot; the completing slot is
    // cleared on the same edge its ack is registered, so busy and ack swap
    // in the same cycle.
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_wr_d   = pend_wr_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        for (int i = 0; i < num_ports; i++) begin
            if (port_ack_d[i]) begin
                pend_vld_d[i] = 1'b0;
            end
            if (!pend_vld_q[i] && (port_rd_req[i] || port_wr_req[i])) begin
                pend_vld_d[i]  = 1'b1;
                pend_wr_d[i]   = port_wr_req[i];
                pend_addr_d[i] = port_addr[i*addr_width +: addr_width];
                pend_data_d[i] = port_wr_data[i*data_width +: data_width];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_d        = grant_q;
        mem_rd_req_d   = 1'b0;
        mem_wr_req_d   = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wr_data_d  = mem_wr_data_q;
        port_ack_d     = '0;
        port_rd_data_d = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    mem_rd_req_d  = !pend_wr_q[pick_idx];
                    mem_wr_req_d  = pend_wr_q[pick_idx];
                    mem_addr_d    = pend_addr_q[pick_idx];
                    mem_wr_data_d = pend_data_q[pick_idx];
                    grant_d       = pick_idx;
                    last_grant_d  = pick_idx;
                    state_d       = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                // mem_addr/mem_wr_data hold their issued values here.
                if (mem_ack) begin
                    port_ack_d[grant_q] = 1'b1;
                    if (!pend_wr_q[grant_q]) begin
                        port_rd_data_d[int'(grant_q)*data_width +: data_width] = mem_rd_data;
                    end
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARB_IDLE;
            last_grant_q   <= idx_width'(num_ports - 1);
            grant_q        <= '0;
            pend_vld_q     <= '0;
            pend_wr_q      <= '0;
            for (int i = 0; i < num_ports; i++) begin
                pend_addr_q[i] <= '0;
                pend_data_q[i] <= '0;
            end
            mem_rd_req_q   <= 1'b0;
            mem_wr_req_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_wr_data_q  <= '0;
            port_ack_q     <= '0;
            port_rd_data_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            grant_q        <= grant_d;
            pend_vld_q     <= pend_vld_d;
            pend_wr_q      <= pend_wr_d;
            pend_addr_q    <= pend_addr_d;
            pend_data_q    <= pend_data_d;
            mem_rd_req_q   <= mem_rd_req_d;
            mem_wr_req_q   <= mem_wr_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            port_ack_q     <= port_ack_d;
            port_rd_data_q <= port_rd_data_d;
        end
    end

    assign port_busy    = pend_vld_q;
    assign port_ack     = port_ack_q;
    assign port_rd_data = port_rd_data_q;
    assign mem_rd_req   = mem_rd_req_q;
    assign mem_wr_req   = mem_wr_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wr_data  = mem_wr_data_q;

    a_inputs_known: assert property (@(posedge clk)
        !$isunknown({rst_n, port_rd_req, port_wr_req, mem_ack, mem_busy}));

    // An ack outside WAIT is a memory protocol error; the FSM ignores it.
    a_ack_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        mem_ack |-> (state_q == ARB_WAIT));

    a_no_req_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ARB_WAIT) |-> !(mem_rd_req_q || mem_wr_req_q));

endmodule
